// File: rtl/regfile_writeback_scheduler.sv
// Writeback scheduler: pending-write scoreboard, ALU/load writeback arbitration,
// registered regfile write port. Define REGFILE_WB_ROUND_ROBIN_EN for round-robin ties.
module regfile_writeback_scheduler #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_enable,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rs1,
  input  logic [4:0]        issue_rs2,
  input  logic [4:0]        issue_rd,
  input  logic              issue_writes,
  output logic              issue_ready,
  input  logic              alu_wb_valid,
  input  logic [4:0]        alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              mem_wb_valid,
  input  logic [4:0]        mem_wb_rd,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              mem_wb_ready,
  output logic              reg_write_enable,
  output logic [4:0]        reg_write_addr,
  output logic [DATA_W-1:0] reg_write_data,
  output logic [NUM_REGS-1:0] busy_mask
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic                raw_s;
  logic                waw_s;
  logic                issue_fire_s;
  logic                alu_grant_s;
  logic                mem_grant_s;
  logic                grant_any_s;
  logic [4:0]          grant_rd_s;
  logic [DATA_W-1:0]   grant_data_s;
  logic                wr_en_r;
  logic [4:0]          wr_addr_r;
  logic [DATA_W-1:0]   wr_data_r;
  logic                unused_addr_bits_s;

`ifdef REGFILE_WB_ROUND_ROBIN_EN
  localparam logic LAST_ALU = 1'b0;
  localparam logic LAST_MEM = 1'b1;
  logic last_grant_r;
`endif

  // Address bit 4 only selects nothing in a 16-entry file.
  assign unused_addr_bits_s = ^{issue_rs1[4], issue_rs2[4], issue_rd[4]};

  // Hazard detection against the registered scoreboard only (no bypass).
  always_comb begin
    raw_s        = busy_r[issue_rs1[3:0]] | busy_r[issue_rs2[3:0]];
    waw_s        = issue_writes & busy_r[issue_rd[3:0]];
    issue_fire_s = 1'b0;
    if (!rst && clk_enable) begin
      issue_fire_s = issue_valid & ~raw_s & ~waw_s;
    end else begin
      issue_fire_s = 1'b0;
    end
  end

  // Writeback arbitration: single winner per enabled cycle.
  always_comb begin
    alu_grant_s = 1'b0;
    mem_grant_s = 1'b0;
    if (!rst && clk_enable) begin
      if (alu_wb_valid && mem_wb_valid) begin
`ifdef REGFILE_WB_ROUND_ROBIN_EN
        if (last_grant_r == LAST_ALU) begin
          mem_grant_s = 1'b1;
        end else begin
          alu_grant_s = 1'b1;
        end
`else
        mem_grant_s = 1'b1;
`endif
      end else if (alu_wb_valid) begin
        alu_grant_s = 1'b1;
      end else if (mem_wb_valid) begin
        mem_grant_s = 1'b1;
      end else begin
        alu_grant_s = 1'b0;
        mem_grant_s = 1'b0;
      end
    end else begin
      alu_grant_s = 1'b0;
      mem_grant_s = 1'b0;
    end
  end

  // Mux the winning request onto the write port payload.
  always_comb begin
    grant_any_s  = alu_grant_s | mem_grant_s;
    grant_rd_s   = 5'd0;
    grant_data_s = {DATA_W{1'b0}};
    if (mem_grant_s) begin
      grant_rd_s   = mem_wb_rd;
      grant_data_s = mem_wb_data;
    end else if (alu_grant_s) begin
      grant_rd_s   = alu_wb_rd;
      grant_data_s = alu_wb_data;
    end else begin
      grant_rd_s   = 5'd0;
      grant_data_s = {DATA_W{1'b0}};
    end
  end

  // Scoreboard next state: clear on commit, set on issue of a writing instruction.
  always_comb begin
    busy_nxt_s = busy_r;
    if (wr_en_r) begin
      busy_nxt_s[wr_addr_r[3:0]] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (issue_fire_s && issue_writes && (issue_rd[3:0] != 4'd0)) begin
      busy_nxt_s[issue_rd[3:0]] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard register; frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else if (clk_enable) begin
      busy_r <= busy_nxt_s;
    end
  end

  // Registered write port; a grant to x0 is consumed without a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= 5'd0;
      wr_data_r <= {DATA_W{1'b0}};
    end else if (clk_enable) begin
      if (grant_any_s) begin
        wr_en_r   <= (grant_rd_s[3:0] != 4'd0);
        wr_addr_r <= grant_rd_s;
        wr_data_r <= grant_data_s;
      end else begin
        wr_en_r   <= 1'b0;
      end
    end
  end

`ifdef REGFILE_WB_ROUND_ROBIN_EN
  // Remember the most recent winner; reset so the load unit wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= LAST_ALU;
    end else if (mem_grant_s) begin
      last_grant_r <= LAST_MEM;
    end else if (alu_grant_s) begin
      last_grant_r <= LAST_ALU;
    end
  end
`endif

  assign issue_ready      = issue_fire_s;
  assign alu_wb_ready     = alu_grant_s;
  assign mem_wb_ready     = mem_grant_s;
  assign reg_write_enable = wr_en_r;
  assign reg_write_addr   = wr_addr_r;
  assign reg_write_data   = wr_data_r;
  assign busy_mask        = {busy_r[NUM_REGS-1:1], 1'b0};

endmodule

// File: tb/tb_regfile_writeback_scheduler.sv
// Directed self-checking bench for regfile_writeback_scheduler.
module tb_regfile_writeback_scheduler;

  logic        clk;
  logic        rst;
  logic        clk_enable;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_writes;
  logic        issue_ready;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        alu_wb_ready;
  logic        mem_wb_valid;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        mem_wb_ready;
  logic        reg_write_enable;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic [15:0] busy_mask;

  int checks_cnt;
  int errors_cnt;

  regfile_writeback_scheduler #(.NUM_REGS(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_writes(issue_writes), .issue_ready(issue_ready),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .reg_write_enable(reg_write_enable), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .busy_mask(busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic wr);
    issue_valid  = v;
    issue_rs1    = rs1;
    issue_rs2    = rs2;
    issue_rd     = rd;
    issue_writes = wr;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_wb_valid = v;
    alu_wb_rd    = rd;
    alu_wb_data  = d;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mem_wb_valid = v;
    mem_wb_rd    = rd;
    mem_wb_data  = d;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst = 1'b1;
    clk_enable = 1'b1;
    set_issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    set_alu(1'b1, 5'd3, 32'h0000_0011);
    set_mem(1'b1, 5'd4, 32'h0000_0022);
    #1;
    check_eq("rst_issue_ready", 32'(issue_ready), 32'd0);
    check_eq("rst_alu_ready", 32'(alu_wb_ready), 32'd0);
    check_eq("rst_mem_ready", 32'(mem_wb_ready), 32'd0);
    tick();
    rst = 1'b0;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("rst_busy", 32'(busy_mask), 32'd0);
    check_eq("rst_wen", 32'(reg_write_enable), 32'd0);
    check_eq("rst_waddr", 32'(reg_write_addr), 32'd0);
    check_eq("rst_wdata", reg_write_data, 32'd0);

    // RAW stall on x5 until its writeback commits
    set_issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
    #1;
    check_eq("raw_issue_x5", 32'(issue_ready), 32'd1);
    tick();
    set_issue(1'b1, 5'd5, 5'd0, 5'd6, 1'b1);
    #1;
    check_eq("raw_busy_x5", 32'(busy_mask), 32'h0000_0020);
    check_eq("raw_stall0", 32'(issue_ready), 32'd0);
    set_alu(1'b1, 5'd5, 32'h0000_1234);
    #1;
    check_eq("raw_alu_grant", 32'(alu_wb_ready), 32'd1);
    check_eq("raw_stall1", 32'(issue_ready), 32'd0);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("raw_wen", 32'(reg_write_enable), 32'd1);
    check_eq("raw_waddr", 32'(reg_write_addr), 32'd5);
    check_eq("raw_wdata", reg_write_data, 32'h0000_1234);
    check_eq("raw_stall2", 32'(issue_ready), 32'd0);
    tick();
    check_eq("raw_busy_clr", 32'(busy_mask), 32'd0);
    check_eq("raw_ready", 32'(issue_ready), 32'd1);
    check_eq("raw_wen_pulse", 32'(reg_write_enable), 32'd0);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check_eq("busy_x6", 32'(busy_mask), 32'h0000_0040);
    set_alu(1'b1, 5'd6, 32'h0000_0066);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    tick();
    check_eq("busy_x6_clr", 32'(busy_mask), 32'd0);

    // rd=0 never marks busy; writeback to x0 granted without a strobe
    set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    check_eq("x0_issue", 32'(issue_ready), 32'd1);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b1, 5'd0, 32'h0000_DEAD);
    #1;
    check_eq("x0_busy", 32'(busy_mask), 32'd0);
    check_eq("x0_grant", 32'(alu_wb_ready), 32'd1);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("x0_wen", 32'(reg_write_enable), 32'd0);

    // Tie between ALU x3 and load x4 right after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_alu(1'b1, 5'd3, 32'hAAAA_0001);
    set_mem(1'b1, 5'd4, 32'h5555_0002);
    #1;
    check_eq("tie0_mem_ready", 32'(mem_wb_ready), 32'd1);
    check_eq("tie0_alu_ready", 32'(alu_wb_ready), 32'd0);
    tick();
    #1;
    check_eq("tie0_wen", 32'(reg_write_enable), 32'd1);
    check_eq("tie0_waddr", 32'(reg_write_addr), 32'd4);
    check_eq("tie0_wdata", reg_write_data, 32'h5555_0002);
`ifdef REGFILE_WB_ROUND_ROBIN_EN
    check_eq("tie1_alu_ready", 32'(alu_wb_ready), 32'd1);
    check_eq("tie1_mem_ready", 32'(mem_wb_ready), 32'd0);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
`else
    check_eq("tie1_alu_ready", 32'(alu_wb_ready), 32'd0);
    check_eq("tie1_mem_ready", 32'(mem_wb_ready), 32'd1);
    tick();
    set_mem(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("tie2_waddr", 32'(reg_write_addr), 32'd4);
    check_eq("tie2_alu_ready", 32'(alu_wb_ready), 32'd1);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
`endif
    #1;
    check_eq("tie_alu_wen", 32'(reg_write_enable), 32'd1);
    check_eq("tie_alu_waddr", 32'(reg_write_addr), 32'd3);
    check_eq("tie_alu_wdata", reg_write_data, 32'hAAAA_0001);
    tick();
    check_eq("tie_done_wen", 32'(reg_write_enable), 32'd0);

    // WAW on x7
    set_issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    #1;
    check_eq("waw_busy", 32'(busy_mask), 32'h0000_0080);
    check_eq("waw_stall0", 32'(issue_ready), 32'd0);
    set_alu(1'b1, 5'd7, 32'h0000_0777);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("waw_wen", 32'(reg_write_enable), 32'd1);
    check_eq("waw_stall1", 32'(issue_ready), 32'd0);
    tick();
    check_eq("waw_accept", 32'(issue_ready), 32'd1);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b1, 5'd7, 32'h0000_0778);
    #1;
    check_eq("waw_busy_again", 32'(busy_mask), 32'h0000_0080);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    tick();
    check_eq("waw_busy_clr", 32'(busy_mask), 32'd0);

    // clk_enable low for three cycles with ALU waiting
    set_issue(1'b1, 5'd0, 5'd0, 5'd2, 1'b1);
    tick();
    clk_enable = 1'b0;
    set_issue(1'b1, 5'd0, 5'd0, 5'd8, 1'b1);
    set_alu(1'b1, 5'd9, 32'h0000_0099);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("stall_alu_ready", 32'(alu_wb_ready), 32'd0);
      check_eq("stall_issue_ready", 32'(issue_ready), 32'd0);
      check_eq("stall_busy", 32'(busy_mask), 32'h0000_0004);
      tick();
    end
    check_eq("stall_wen", 32'(reg_write_enable), 32'd0);
    clk_enable = 1'b1;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check_eq("resume_grant", 32'(alu_wb_ready), 32'd1);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("resume_wen", 32'(reg_write_enable), 32'd1);
    check_eq("resume_waddr", 32'(reg_write_addr), 32'd9);
    check_eq("resume_busy", 32'(busy_mask), 32'h0000_0004);

    // Reset with busy=0x8006 and a write registered
    set_issue(1'b1, 5'd0, 5'd0, 5'd1, 1'b1);
    tick();
    set_issue(1'b1, 5'd0, 5'd0, 5'd15, 1'b1);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b1, 5'd1, 32'h0000_0101);
    #1;
    check_eq("pre_rst_busy", 32'(busy_mask), 32'h0000_8006);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("pre_rst_wen", 32'(reg_write_enable), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    check_eq("post_rst_busy", 32'(busy_mask), 32'd0);
    check_eq("post_rst_wen", 32'(reg_write_enable), 32'd0);
    check_eq("post_rst_wdata", reg_write_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
